// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority over a FIFO-buffered long-latency source.
// Optional macro WB_BYPASS_EN lets a beat skip the FIFO when the arbiter is idle.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wd,
  input  logic        ll_valid,
  output logic        ll_ready,
  input  logic [4:0]  ll_rd,
  input  logic [31:0] ll_wd,
  input  logic        iss_alloc,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  q_a1,
  input  logic [4:0]  q_a2,
  output logic        busy_a1,
  output logic        busy_a2,
  output logic        pipe_stall,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [4:0]   mem_rd_q [DEPTH];
  logic [31:0]  mem_wd_q [DEPTH];
  logic [31:0]  busy_q, busy_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         stall_q, stall_d;
  logic         we_q, we_d;
  logic [4:0]   a_q, a_d;
  logic [31:0]  wd_q, wd_d;

  logic full, empty, accept_nz, pipe_eff, pop, push, bypass, ll_wr;

  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty    = (wptr_q == rptr_q);
  assign ll_ready = rst && !full;

  always_comb begin
    accept_nz = ll_valid && ll_ready && (ll_rd != 5'd0);
    pipe_eff  = pipe_we && (pipe_rd != 5'd0);
    pop       = !pipe_eff && !empty;
`ifdef WB_BYPASS_EN
    bypass    = accept_nz && empty && !pipe_eff;
`else
    bypass    = 1'b0;
`endif
    push      = accept_nz && !bypass;
    wptr_d    = wptr_q + (AW+1)'(push);
    rptr_d    = rptr_q + (AW+1)'(pop);

    we_d  = 1'b0;
    a_d   = a_q;
    wd_d  = wd_q;
    ll_wr = 1'b0;
    if (pipe_eff) begin
      we_d = 1'b1;
      a_d  = pipe_rd;
      wd_d = pipe_wd;
    end else if (pop) begin
      we_d  = 1'b1;
      a_d   = mem_rd_q[rptr_q[AW-1:0]];
      wd_d  = mem_wd_q[rptr_q[AW-1:0]];
      ll_wr = 1'b1;
    end else if (bypass) begin
      we_d  = 1'b1;
      a_d   = ll_rd;
      wd_d  = ll_wd;
      ll_wr = 1'b1;
    end

    // Clear first so a same-cycle allocation to the same register wins.
    busy_d = busy_q;
    if (ll_wr) busy_d[a_d] = 1'b0;
    if (iss_alloc && (iss_rd != 5'd0)) busy_d[iss_rd] = 1'b1;

    stall_d = 1'b0;
    cnt_d   = cnt_q;
    if (empty || pop) begin
      cnt_d = '0;
    end else if (cnt_q + 4'd1 == 4'(STARVE_MAX)) begin
      cnt_d   = '0;
      stall_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      busy_q  <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      we_q    <= 1'b0;
      a_q     <= '0;
      wd_q    <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      we_q    <= we_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd_q[wptr_q[AW-1:0]] <= ll_rd;
      mem_wd_q[wptr_q[AW-1:0]] <= ll_wd;
    end
  end

  assign busy_a1    = (q_a1 != 5'd0) && busy_q[q_a1];
  assign busy_a2    = (q_a2 != 5'd0) && busy_q[q_a2];
  assign pipe_stall = stall_q;
  assign WE3        = we_q;
  assign A3         = a_q;
  assign WD3        = wd_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (DEPTH=2, STARVE_MAX=4); honours WB_BYPASS_EN.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_wd = '0;
  logic        ll_valid = 1'b0;
  logic        ll_ready;
  logic [4:0]  ll_rd = '0;
  logic [31:0] ll_wd = '0;
  logic        iss_alloc = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic [4:0]  q_a1 = '0;
  logic [4:0]  q_a2 = '0;
  logic        busy_a1, busy_a2, pipe_stall, WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  regfile_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_wd(ll_wd),
    .iss_alloc(iss_alloc), .iss_rd(iss_rd),
    .q_a1(q_a1), .q_a2(q_a2), .busy_a1(busy_a1), .busy_a2(busy_a2),
    .pipe_stall(pipe_stall), .WE3(WE3), .A3(A3), .WD3(WD3)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; ll_valid = 1'b1; ll_rd = 5'd4; ll_wd = 32'h44;
    pipe_we = 1'b1; pipe_rd = 5'd6; pipe_wd = 32'h66;
    iss_alloc = 1'b1; iss_rd = 5'd9; q_a1 = 5'd9;
    tick; tick;
    n_chk++; if (WE3 !== 1'b0) $display("FAIL rst_we3 got %0b want 0", WE3); else n_pass++;
    n_chk++; if (A3 !== 5'd0) $display("FAIL rst_a3 got %0d want 0", A3); else n_pass++;
    n_chk++; if (WD3 !== 32'd0) $display("FAIL rst_wd3 got %h want 0", WD3); else n_pass++;
    n_chk++; if (ll_ready !== 1'b0) $display("FAIL rst_ll_ready got %0b want 0", ll_ready); else n_pass++;
    n_chk++; if (busy_a1 !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy_a1); else n_pass++;
    n_chk++; if (pipe_stall !== 1'b0) $display("FAIL rst_stall got %0b want 0", pipe_stall); else n_pass++;
    ll_valid = 1'b0; pipe_we = 1'b0; iss_alloc = 1'b0;
    rst = 1'b1;
    tick;
    n_chk++; if (WE3 !== 1'b0) $display("FAIL rst_release_we3 got %0b want 0", WE3); else n_pass++;
    n_chk++; if (ll_ready !== 1'b1) $display("FAIL rst_release_ready got %0b want 1", ll_ready); else n_pass++;
    n_chk++; if (busy_a1 !== 1'b0) $display("FAIL rst_release_busy got %0b want 0", busy_a1); else n_pass++;
  endtask

  task automatic test_pipe_write;
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wd = 32'hDEADBEEF;
    tick;
    pipe_we = 1'b0;
    n_chk++; if (WE3 !== 1'b1) $display("FAIL pipe_we3 got %0b want 1", WE3); else n_pass++;
    n_chk++; if (A3 !== 5'd5) $display("FAIL pipe_a3 got %0d want 5", A3); else n_pass++;
    n_chk++; if (WD3 !== 32'hDEADBEEF) $display("FAIL pipe_wd3 got %h want deadbeef", WD3); else n_pass++;
    pipe_we = 1'b1; pipe_rd = 5'd0; pipe_wd = 32'h12345678;
    tick;
    pipe_we = 1'b0;
    n_chk++; if (WE3 !== 1'b0) $display("FAIL pipe_r0_we3 got %0b want 0", WE3); else n_pass++;
    n_chk++; if (A3 !== 5'd5) $display("FAIL pipe_hold_a3 got %0d want 5", A3); else n_pass++;
    n_chk++; if (WD3 !== 32'hDEADBEEF) $display("FAIL pipe_hold_wd3 got %h want deadbeef", WD3); else n_pass++;
  endtask

  task automatic test_contention;
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'h30;
    ll_valid = 1'b1; ll_rd = 5'd7; ll_wd = 32'h11;
    n_chk++; if (ll_ready !== 1'b1) $display("FAIL cont_ready got %0b want 1", ll_ready); else n_pass++;
    tick;
    ll_valid = 1'b0;
    n_chk++; if (A3 !== 5'd3 || WE3 !== 1'b1) $display("FAIL cont_first got we=%0b a3=%0d want we=1 a3=3", WE3, A3); else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      pipe_wd = 32'h30 + i;
      tick;
      n_chk++; if (pipe_stall !== (i == 4)) $display("FAIL cont_stall%0d got %0b want %0b", i, pipe_stall, (i == 4)); else n_pass++;
      n_chk++; if (A3 !== 5'd3 || WE3 !== 1'b1) $display("FAIL cont_pipe%0d got we=%0b a3=%0d want we=1 a3=3", i, WE3, A3); else n_pass++;
    end
    pipe_we = 1'b0;
    tick;
    n_chk++; if (WE3 !== 1'b1 || A3 !== 5'd7 || WD3 !== 32'h11)
      $display("FAIL cont_ll got we=%0b a3=%0d wd=%h want we=1 a3=7 wd=11", WE3, A3, WD3); else n_pass++;
    n_chk++; if (pipe_stall !== 1'b0) $display("FAIL cont_stall_pulse got %0b want 0", pipe_stall); else n_pass++;
    tick;
    n_chk++; if (WE3 !== 1'b0) $display("FAIL cont_idle got %0b want 0", WE3); else n_pass++;
  endtask

  task automatic test_fifo_full;
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'h33;
    ll_valid = 1'b1; ll_rd = 5'd1; ll_wd = 32'hA1;
    tick;
    ll_rd = 5'd2; ll_wd = 32'hB2;
    n_chk++; if (ll_ready !== 1'b1) $display("FAIL full_ready1 got %0b want 1", ll_ready); else n_pass++;
    tick;
    ll_rd = 5'd4; ll_wd = 32'hC4;
    n_chk++; if (ll_ready !== 1'b0) $display("FAIL full_ready2 got %0b want 0", ll_ready); else n_pass++;
    for (int k = 3; k <= 5; k++) begin
      tick;
      n_chk++; if (ll_ready !== 1'b0) $display("FAIL full_hold%0d got %0b want 0", k, ll_ready); else n_pass++;
      n_chk++; if (pipe_stall !== (k == 5)) $display("FAIL full_stall%0d got %0b want %0b", k, pipe_stall, (k == 5)); else n_pass++;
    end
    pipe_we = 1'b0;
    tick;
    n_chk++; if (WE3 !== 1'b1 || A3 !== 5'd1 || WD3 !== 32'hA1)
      $display("FAIL full_pop1 got we=%0b a3=%0d wd=%h want we=1 a3=1 wd=a1", WE3, A3, WD3); else n_pass++;
    n_chk++; if (ll_ready !== 1'b1) $display("FAIL full_ready3 got %0b want 1", ll_ready); else n_pass++;
    tick;
    ll_valid = 1'b0;
    n_chk++; if (WE3 !== 1'b1 || A3 !== 5'd2 || WD3 !== 32'hB2)
      $display("FAIL full_pop2 got we=%0b a3=%0d wd=%h want we=1 a3=2 wd=b2", WE3, A3, WD3); else n_pass++;
    tick;
    n_chk++; if (WE3 !== 1'b1 || A3 !== 5'd4 || WD3 !== 32'hC4)
      $display("FAIL full_pop3 got we=%0b a3=%0d wd=%h want we=1 a3=4 wd=c4", WE3, A3, WD3); else n_pass++;
    tick;
    n_chk++; if (WE3 !== 1'b0) $display("FAIL full_drain got %0b want 0", WE3); else n_pass++;
  endtask

  task automatic test_scoreboard;
    iss_alloc = 1'b1; iss_rd = 5'd9; q_a1 = 5'd9; q_a2 = 5'd10;
    tick;
    iss_alloc = 1'b0;
    n_chk++; if (busy_a1 !== 1'b1) $display("FAIL sb_set got %0b want 1", busy_a1); else n_pass++;
    n_chk++; if (busy_a2 !== 1'b0) $display("FAIL sb_other got %0b want 0", busy_a2); else n_pass++;
    pipe_we = 1'b1; pipe_rd = 5'd3; ll_valid = 1'b1; ll_rd = 5'd9; ll_wd = 32'h99;
    tick;
    pipe_we = 1'b0; ll_valid = 1'b0;
    n_chk++; if (busy_a1 !== 1'b1) $display("FAIL sb_pending got %0b want 1", busy_a1); else n_pass++;
    tick;
    n_chk++; if (WE3 !== 1'b1 || A3 !== 5'd9) $display("FAIL sb_write got we=%0b a3=%0d want we=1 a3=9", WE3, A3); else n_pass++;
    n_chk++; if (busy_a1 !== 1'b0) $display("FAIL sb_clear got %0b want 0", busy_a1); else n_pass++;
    iss_alloc = 1'b1; iss_rd = 5'd9;
    tick;
    iss_alloc = 1'b0;
    pipe_we = 1'b1; ll_valid = 1'b1;
    tick;
    pipe_we = 1'b0; ll_valid = 1'b0;
    iss_alloc = 1'b1; iss_rd = 5'd9;
    tick;
    iss_alloc = 1'b0;
    n_chk++; if (WE3 !== 1'b1 || A3 !== 5'd9) $display("FAIL sb_write2 got we=%0b a3=%0d want we=1 a3=9", WE3, A3); else n_pass++;
    n_chk++; if (busy_a1 !== 1'b1) $display("FAIL sb_set_wins got %0b want 1", busy_a1); else n_pass++;
    q_a2 = 5'd9;
    #1;
    n_chk++; if (busy_a2 !== 1'b1) $display("FAIL sb_port2 got %0b want 1", busy_a2); else n_pass++;
    iss_alloc = 1'b1; iss_rd = 5'd0; q_a1 = 5'd0;
    tick;
    iss_alloc = 1'b0;
    n_chk++; if (busy_a1 !== 1'b0) $display("FAIL sb_r0 got %0b want 0", busy_a1); else n_pass++;
  endtask

  task automatic test_bypass;
    ll_valid = 1'b1; ll_rd = 5'd12; ll_wd = 32'hA5A5A5A5;
    tick;
    ll_valid = 1'b0;
`ifdef WB_BYPASS_EN
    n_chk++; if (WE3 !== 1'b1 || A3 !== 5'd12 || WD3 !== 32'hA5A5A5A5)
      $display("FAIL byp_n1 got we=%0b a3=%0d wd=%h want we=1 a3=12 wd=a5a5a5a5", WE3, A3, WD3); else n_pass++;
    tick;
    n_chk++; if (WE3 !== 1'b0) $display("FAIL byp_n2 got %0b want 0", WE3); else n_pass++;
`else
    n_chk++; if (WE3 !== 1'b0) $display("FAIL byp_n1 got %0b want 0", WE3); else n_pass++;
    tick;
    n_chk++; if (WE3 !== 1'b1 || A3 !== 5'd12 || WD3 !== 32'hA5A5A5A5)
      $display("FAIL byp_n2 got we=%0b a3=%0d wd=%h want we=1 a3=12 wd=a5a5a5a5", WE3, A3, WD3); else n_pass++;
`endif
    tick;
    n_chk++; if (WE3 !== 1'b0) $display("FAIL byp_idle got %0b want 0", WE3); else n_pass++;
  endtask

  task automatic test_discard_r0;
    ll_valid = 1'b1; ll_rd = 5'd0; ll_wd = 32'hFFFF;
    n_chk++; if (ll_ready !== 1'b1) $display("FAIL r0_ready got %0b want 1", ll_ready); else n_pass++;
    tick;
    ll_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (WE3 !== 1'b0) $display("FAIL r0_we3_%0d got %0b want 0", i, WE3); else n_pass++;
      tick;
    end
  endtask

  task automatic test_reset_mid;
    pipe_we = 1'b1; pipe_rd = 5'd3; ll_valid = 1'b1; ll_rd = 5'd20; ll_wd = 32'h20;
    iss_alloc = 1'b1; iss_rd = 5'd20; q_a1 = 5'd20;
    tick;
    pipe_we = 1'b0; ll_valid = 1'b0; iss_alloc = 1'b0;
    n_chk++; if (busy_a1 !== 1'b1) $display("FAIL mid_busy_pre got %0b want 1", busy_a1); else n_pass++;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (WE3 !== 1'b0) $display("FAIL mid_we3_%0d got %0b want 0", i, WE3); else n_pass++;
      n_chk++; if (busy_a1 !== 1'b0) $display("FAIL mid_busy_%0d got %0b want 0", i, busy_a1); else n_pass++;
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_pipe_write;
    test_contention;
    test_fifo_full;
    test_scoreboard;
    test_bypass;
    test_discard_r0;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
